kb_div3_seq_ctrl: RTL and testbench
===================================

# kb_div3_seq_ctrl

Sequencer and result stage for the 4-bit-per-cycle divide-by-3 shift-register datapath. It accepts a dividend over a valid/ready handshake and drives the datapath's `shift_en` and `divident` inputs. It counts the digit steps, captures the final quotient and remainder, and presents them downstream over a second valid/ready handshake. It also raises a self-check flag when the result fails the check `quotient*3 + remainder == dividend`.

## Interface
- `SIZE`, 20, dividend/quotient width; must be a multiple of 4. Localparam `DIGITS = SIZE/4` (5 at default).
- `sys_clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream offers `in_divident`.
- `in_ready`  out  1  controller can accept a dividend.
- `in_divident`  in  SIZE  dividend to divide by 3.
- `shift_en`  out  1  to datapath: 1 = load `dp_divident`, 0 = perform one digit step.
- `dp_divident`  out  SIZE  to datapath `divident`.
- `dp_quotient`  in  SIZE  from datapath `quotient`.
- `dp_reminder`  in  2  from datapath `reminder`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_quotient`  out  SIZE  captured quotient.
- `out_reminder`  out  2  captured remainder.
- `chk_err`  out  1  self-check failure; qualified by `out_valid`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- `in_ready` = (state == IDLE), decoded combinationally.
- `busy` = (state != IDLE).
- All other outputs are registered.

IDLE:
- On `in_valid && in_ready`:
  - `dvd_q <= in_divident`
  - `shift_en <= 1`
  - `cnt <= 0`
  - go to LOAD.
- `dp_divident` is driven from `dvd_q`.

LOAD (exactly one cycle, `shift_en` = 1):
- The datapath loads `dvd_q` and clears its quotient and remainder at the edge that ends this cycle.
- At that edge: `shift_en <= 0`, go to RUN.

RUN (`shift_en` = 0):
- Each edge with `cnt < DIGITS`: `cnt <= cnt + 1`. The datapath produces one quotient nibble per such edge.
- At the edge with `cnt == DIGITS` (the datapath result has been stable for one cycle):
  - `out_quotient <= dp_quotient`
  - `out_reminder <= dp_reminder`
  - `chk_err <= check_fail`
  - `out_valid <= 1`
  - go to DONE.
- `check_fail` is computed at SIZE+2 bits, zero-extended: `dp_reminder == 3` OR `dp_quotient*3 + dp_reminder != dvd_q`.
- The datapath shifts again on the capture edge. This is harmless because the controller samples the pre-edge values.

DONE:
- Hold `out_*` and `chk_err` stable while `out_ready` is 0.
- At an edge with `out_ready` = 1: `out_valid <= 0`, go to IDLE.
- `out_quotient`, `out_reminder` and `chk_err` keep their last values after the handshake.

General rules:
- No overlap: a new dividend is never accepted while busy.
- `in_valid` outside IDLE is ignored; upstream must hold it.
- `cnt` width is `$clog2(DIGITS+1)`. It never wraps.

Reset (asynchronous, any time, including mid-RUN):
- Values: state IDLE, `shift_en` 0, `out_valid` 0, `out_quotient` 0, `out_reminder` 0, `chk_err` 0, `dvd_q` 0, `cnt` 0.
- Consequences: `dp_divident` 0; `in_ready` 1 and `busy` 0 immediately.
- Any transaction in flight is dropped with no output.

## Timing
- Edge t0 (input handshake) → `shift_en` high during cycle t0–t1 → datapath loads at t1.
- Digit steps at t2..t(1+DIGITS).
- Capture at t(2+DIGITS); `out_valid` is high from that edge onward.
- Latency from handshake edge to `out_valid`: DIGITS+2 = 7 cycles at default.
- Minimum initiation interval with `out_ready` held at 1: DIGITS+4 = 9 cycles.
  - 7 cycles of latency.
  - 1 DONE cycle, with the output handshake on its ending edge.
  - 1 IDLE cycle before the next input handshake.
- `shift_en` is high for exactly one cycle per transaction and never high outside LOAD.
- Out-of-reset: the first input handshake is possible at the first edge after `reset_n` deasserts, with `in_valid` high.

## Test plan
- Reset, then idle 5 cycles: `in_ready`=1, `busy`=0, `shift_en`=0, `out_valid`=0, `out_quotient`=0, `out_reminder`=0, `chk_err`=0.
- Dividend 100, `out_ready`=1, with the real datapath:
  - `out_valid` rises 7 edges after acceptance.
  - `out_quotient`=33, `out_reminder`=1, `chk_err`=0.
  - `shift_en` high for exactly 1 cycle.
- Boundaries, each with `chk_err`=0:
  - 0 → 0 r0
  - 2 → 0 r2
  - 3 → 1 r0
  - 0xFFFFF → 349525 r0
  - 0xFFFFE → 349524 r2
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE.
  - `out_valid`=1 and data are stable; `in_ready`=0; a concurrent `in_valid` with 7 is not accepted.
  - Release `out_ready`: 7 is accepted in IDLE, giving 2 r1 after 7 more cycles.
  - Back-to-back streams reach the 9-cycle interval.
- Reset pulse 3 cycles into RUN:
  - All outputs clear asynchronously and no `out_valid` pulse appears.
  - A following dividend of 1000 gives 333 r1.
- Error injection: the bench model corrupts `dp_quotient` LSB at capture for dividend 9 (returns 2 r0 instead of 3 r0).
  - `chk_err`=1 with `out_valid`.
  - Forcing `dp_reminder`=3 also gives `chk_err`=1.

Source files
------------

// File: rtl/kb_div3_seq_ctrl.sv
// kb_div3_seq_ctrl
// Sequencer and result stage for the 4-bit-per-cycle divide-by-3 datapath.
// Accepts a dividend over in_valid/in_ready and loads it into the datapath
// with a one-cycle shift_en pulse. It then counts DIGITS digit steps and
// captures the quotient and remainder. The result is presented over
// out_valid/out_ready, together with a self-check flag.
// Ports:
//   sys_clock, reset_n         clock, async active-low reset
//   in_valid/in_ready          dividend handshake (in_ready = IDLE)
//   in_divident                dividend
//   shift_en, dp_divident      datapath control/load value
//   dp_quotient, dp_reminder   datapath result
//   out_valid/out_ready        result handshake
//   out_quotient, out_reminder captured result
//   chk_err                    quotient*3+remainder != dividend (with out_valid)
//   busy                       controller not in IDLE
module kb_div3_seq_ctrl #(
   parameter int unsigned SIZE = 20
) (
   input  logic            sys_clock,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] in_divident,
   output logic            shift_en,
   output logic [SIZE-1:0] dp_divident,
   input  logic [SIZE-1:0] dp_quotient,
   input  logic [1:0]      dp_reminder,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE-1:0] out_quotient,
   output logic [1:0]      out_reminder,
   output logic            chk_err,
   output logic            busy
);

   localparam int unsigned DIGITS = SIZE / 4;
   localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
   localparam int unsigned CHK_W  = SIZE + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic              shift_en_q, shift_en_d;
   logic              out_valid_q, out_valid_d;
   logic [SIZE-1:0]   out_quotient_q, out_quotient_d;
   logic [1:0]        out_reminder_q, out_reminder_d;
   logic              chk_err_q, chk_err_d;
   logic [SIZE-1:0]   dvd_q, dvd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [CHK_W-1:0]  chk_sum_c;
   logic              check_fail_c;

   // quotient*3 + remainder as q + 2q + r; widened so it cannot overflow
   always_comb begin
      chk_sum_c    = {2'b00, dp_quotient} + {1'b0, dp_quotient, 1'b0}
                     + CHK_W'(dp_reminder);
      check_fail_c = (dp_reminder == 2'd3) || (chk_sum_c != CHK_W'(dvd_q));
   end

   // State and registered outputs
   always_ff @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         shift_en_q     <= 1'b0;
         out_valid_q    <= 1'b0;
         out_quotient_q <= '0;
         out_reminder_q <= '0;
         chk_err_q      <= 1'b0;
         dvd_q          <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         shift_en_q     <= shift_en_d;
         out_valid_q    <= out_valid_d;
         out_quotient_q <= out_quotient_d;
         out_reminder_q <= out_reminder_d;
         chk_err_q      <= chk_err_d;
         dvd_q          <= dvd_d;
         cnt_q          <= cnt_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d        = state_q;
      shift_en_d     = shift_en_q;
      out_valid_d    = out_valid_q;
      out_quotient_d = out_quotient_q;
      out_reminder_d = out_reminder_q;
      chk_err_d      = chk_err_q;
      dvd_d          = dvd_q;
      cnt_d          = cnt_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               dvd_d      = in_divident;
               shift_en_d = 1'b1;
               cnt_d      = '0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            shift_en_d = 1'b0;
            state_d    = RUN;
         end
         RUN: begin
            if (cnt_q < CNT_W'(DIGITS)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               // datapath result is stable; sample it before it shifts again
               out_quotient_d = dp_quotient;
               out_reminder_d = dp_reminder;
               chk_err_d      = check_fail_c;
               out_valid_d    = 1'b1;
               state_d        = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready     = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign shift_en     = shift_en_q;
   assign dp_divident  = dvd_q;
   assign out_valid    = out_valid_q;
   assign out_quotient = out_quotient_q;
   assign out_reminder = out_reminder_q;
   assign chk_err      = chk_err_q;

endmodule

// File: tb/tb_kb_div3_seq_ctrl.sv
// tb_kb_div3_seq_ctrl
// Bench for kb_div3_seq_ctrl. It contains a behavioural model of the
// 4-bit-per-cycle divide-by-3 datapath, with optional fault injection on its
// outputs. Expected results come from plain integer division.
module tb_kb_div3_seq_ctrl;

   localparam int unsigned SIZE = 20;

   logic            sys_clock = 1'b0;
   logic            reset_n;
   logic            in_valid;
   logic            in_ready;
   logic [SIZE-1:0] in_divident;
   logic            shift_en;
   logic [SIZE-1:0] dp_divident;
   logic [SIZE-1:0] dp_quotient;
   logic [1:0]      dp_reminder;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] out_quotient;
   logic [1:0]      out_reminder;
   logic            chk_err;
   logic            busy;

   int checks = 0;
   int errors = 0;

   logic inj_q = 1'b0;
   logic inj_r = 1'b0;

   always #5 sys_clock = ~sys_clock;

   kb_div3_seq_ctrl #(.SIZE(SIZE)) dut (
      .sys_clock    (sys_clock),
      .reset_n      (reset_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_divident  (in_divident),
      .shift_en     (shift_en),
      .dp_divident  (dp_divident),
      .dp_quotient  (dp_quotient),
      .dp_reminder  (dp_reminder),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_quotient (out_quotient),
      .out_reminder (out_reminder),
      .chk_err      (chk_err),
      .busy         (busy)
   );

   // Datapath model: load on shift_en, else one long-division digit per edge
   logic [SIZE-1:0] dp_sh, dp_qr;
   logic [1:0]      dp_rr;
   int unsigned     dp_v;

   always_comb dp_v = 16 * int'(dp_rr) + int'(dp_sh[SIZE-1 -: 4]);

   always @(posedge sys_clock or negedge reset_n) begin
      if (!reset_n) begin
         dp_sh <= '0;
         dp_qr <= '0;
         dp_rr <= '0;
      end else if (shift_en) begin
         dp_sh <= dp_divident;
         dp_qr <= '0;
         dp_rr <= '0;
      end else begin
         dp_sh <= dp_sh << 4;
         dp_qr <= {dp_qr[SIZE-5:0], 4'(dp_v / 3)};
         dp_rr <= 2'(dp_v % 3);
      end
   end

   assign dp_quotient = dp_qr ^ SIZE'(inj_q);
   assign dp_reminder = inj_r ? 2'd3 : dp_rr;

   // Reference: expected capture given the injected faults
   function automatic void ref_div(input logic [SIZE-1:0] d, input logic iq, input logic ir,
                                   output logic [SIZE-1:0] q, output logic [1:0] r,
                                   output logic e);
      longint unsigned dv;
      dv = longint'(d);
      q  = SIZE'(dv / 3) ^ SIZE'(iq);
      r  = ir ? 2'd3 : 2'(dv % 3);
      e  = (r == 2'd3) || ((longint'(q) * 3 + longint'(r)) != dv);
   endfunction

   // Drives one transaction with out_ready=1; returns latency and capture
   task automatic run_txn(input logic [SIZE-1:0] d, output int lat, output int se_cnt,
                          output logic [SIZE-1:0] q, output logic [1:0] r, output logic e);
      int w;
      w = 0;
      out_ready = 1'b1;
      while (!in_ready && w < 50) begin
         @(posedge sys_clock); #1;
         w++;
      end
      in_divident = d;
      in_valid    = 1'b1;
      @(posedge sys_clock); #1;
      in_valid = 1'b0;
      lat      = 0;
      se_cnt   = shift_en ? 1 : 0;
      while (!out_valid && lat < 30) begin
         @(posedge sys_clock); #1;
         lat++;
         if (shift_en) se_cnt++;
      end
      q = out_quotient;
      r = out_reminder;
      e = chk_err;
      @(posedge sys_clock); #1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_divident = '0;
      repeat (2) @(posedge sys_clock);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge sys_clock); #1;
         checks++;
         if ({in_ready, busy, shift_en, out_valid, chk_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags cyc%0d: got %b expected 10000", i,
                     {in_ready, busy, shift_en, out_valid, chk_err});
         end
         checks++;
         if (out_quotient !== '0 || out_reminder !== 2'd0 || dp_divident !== '0) begin
            errors++;
            $display("FAIL reset_data cyc%0d: got q=%0d r=%0d dp=%0d expected 0 0 0", i,
                     out_quotient, out_reminder, dp_divident);
         end
      end
   endtask

   task automatic test_basic();
      int lat, se;
      logic [SIZE-1:0] q;
      logic [1:0] r;
      logic e;
      run_txn(SIZE'(100), lat, se, q, r, e);
      checks++;
      if (lat !== 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", lat); end
      checks++;
      if (se !== 1) begin errors++; $display("FAIL basic_shift_en_cycles: got %0d expected 1", se); end
      checks++;
      if (q !== SIZE'(33) || r !== 2'd1 || e !== 1'b0) begin
         errors++;
         $display("FAIL basic_result: got %0d r%0d err%0d expected 33 r1 err0", q, r, e);
      end
   endtask

   task automatic test_boundaries();
      logic [SIZE-1:0] vals [5];
      int lat, se;
      logic [SIZE-1:0] q, eq;
      logic [1:0] r, er;
      logic e, ee;
      vals = '{SIZE'(0), SIZE'(2), SIZE'(3), SIZE'(20'hFFFFF), SIZE'(20'hFFFFE)};
      for (int i = 0; i < 5; i++) begin
         run_txn(vals[i], lat, se, q, r, e);
         ref_div(vals[i], 1'b0, 1'b0, eq, er, ee);
         checks++;
         if (q !== eq || r !== er || e !== ee || lat !== 7) begin
            errors++;
            $display("FAIL boundary_%0d: got %0d r%0d err%0d lat%0d expected %0d r%0d err%0d lat7",
                     vals[i], q, r, e, lat, eq, er, ee);
         end
      end
   endtask

   task automatic test_random();
      logic [SIZE-1:0] d, q, eq;
      logic [1:0] r, er;
      logic e, ee;
      int lat, se;
      for (int i = 0; i < 16; i++) begin
         d = SIZE'($urandom);
         run_txn(d, lat, se, q, r, e);
         ref_div(d, 1'b0, 1'b0, eq, er, ee);
         checks++;
         if (q !== eq || r !== er || e !== ee || lat !== 7 || se !== 1) begin
            errors++;
            $display("FAIL random_%0d: got %0d r%0d err%0d lat%0d se%0d expected %0d r%0d err%0d lat7 se1",
                     d, q, r, e, lat, se, eq, er, ee);
         end
      end
   endtask

   task automatic test_backpressure();
      int w, lat;
      out_ready   = 1'b0;
      in_divident = SIZE'(500);
      in_valid    = 1'b1;
      @(posedge sys_clock); #1;
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 30) begin
         @(posedge sys_clock); #1;
         w++;
      end
      checks++;
      if (out_quotient !== SIZE'(166) || out_reminder !== 2'd2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_first: got v%0d %0d r%0d expected v1 166 r2", out_valid, out_quotient, out_reminder);
      end
      in_divident = SIZE'(7);
      in_valid    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge sys_clock); #1;
         checks++;
         if (out_valid !== 1'b1 || out_quotient !== SIZE'(166) || out_reminder !== 2'd2
             || in_ready !== 1'b0 || busy !== 1'b1 || dp_divident !== SIZE'(500)) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: got v%0d %0d r%0d rdy%0d busy%0d dp%0d expected v1 166 r2 rdy0 busy1 dp500",
                     i, out_valid, out_quotient, out_reminder, in_ready, busy, dp_divident);
         end
      end
      out_ready = 1'b1;
      @(posedge sys_clock); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_quotient !== SIZE'(166)) begin
         errors++;
         $display("FAIL bp_release: got v%0d rdy%0d q%0d expected v0 rdy1 q166", out_valid, in_ready, out_quotient);
      end
      @(posedge sys_clock); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge sys_clock); #1;
         lat++;
      end
      checks++;
      if (lat !== 7 || out_quotient !== SIZE'(2) || out_reminder !== 2'd1 || chk_err !== 1'b0) begin
         errors++;
         $display("FAIL bp_second: got lat%0d %0d r%0d err%0d expected lat7 2 r1 err0",
                  lat, out_quotient, out_reminder, chk_err);
      end
      @(posedge sys_clock); #1;
   endtask

   task automatic test_back_to_back();
      localparam int N = 4;
      logic [SIZE-1:0] vals [N];
      logic [SIZE-1:0] exp_q [$];
      int k, got, cyc, prev;
      logic [SIZE-1:0] eq, d;
      logic [1:0] er;
      logic ee;
      for (int i = 0; i < N; i++) vals[i] = SIZE'($urandom);
      out_ready = 1'b1;
      k = 0; got = 0; cyc = 0; prev = -1;
      while (got < N && cyc < 200) begin
         if (out_valid) begin
            d = exp_q.pop_front();
            ref_div(d, 1'b0, 1'b0, eq, er, ee);
            checks++;
            if (out_quotient !== eq || out_reminder !== er || chk_err !== ee) begin
               errors++;
               $display("FAIL b2b_result_%0d: got %0d r%0d err%0d expected %0d r%0d err%0d",
                        got, out_quotient, out_reminder, chk_err, eq, er, ee);
            end
            if (prev >= 0) begin
               checks++;
               if (cyc - prev !== 9) begin
                  errors++;
                  $display("FAIL b2b_interval_%0d: got %0d expected 9", got, cyc - prev);
               end
            end
            prev = cyc;
            got++;
         end
         if (in_ready) begin
            in_valid = (k < N);
            if (k < N) begin
               in_divident = vals[k];
               exp_q.push_back(vals[k]);
               k++;
            end
         end
         @(posedge sys_clock); #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== N) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d results expected %0d", got, N);
      end
   endtask

   task automatic test_error_inject();
      int lat, se;
      logic [SIZE-1:0] q;
      logic [1:0] r;
      logic e;
      inj_q = 1'b1;
      run_txn(SIZE'(9), lat, se, q, r, e);
      inj_q = 1'b0;
      checks++;
      if (q !== SIZE'(2) || r !== 2'd0 || e !== 1'b1) begin
         errors++;
         $display("FAIL inject_quotient: got %0d r%0d err%0d expected 2 r0 err1", q, r, e);
      end
      inj_r = 1'b1;
      run_txn(SIZE'(9), lat, se, q, r, e);
      inj_r = 1'b0;
      checks++;
      if (q !== SIZE'(3) || r !== 2'd3 || e !== 1'b1) begin
         errors++;
         $display("FAIL inject_reminder: got %0d r%0d err%0d expected 3 r3 err1", q, r, e);
      end
      run_txn(SIZE'(9), lat, se, q, r, e);
      checks++;
      if (q !== SIZE'(3) || r !== 2'd0 || e !== 1'b0) begin
         errors++;
         $display("FAIL inject_recover: got %0d r%0d err%0d expected 3 r0 err0", q, r, e);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, se, pulses;
      logic [SIZE-1:0] q;
      logic [1:0] r;
      logic e;
      out_ready   = 1'b1;
      in_divident = SIZE'(12345);
      in_valid    = 1'b1;
      @(posedge sys_clock); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge sys_clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, shift_en, out_valid, chk_err} !== 5'b10000 || out_quotient !== '0
          || out_reminder !== 2'd0 || dp_divident !== '0) begin
         errors++;
         $display("FAIL mid_run_reset: got flags %b q%0d r%0d dp%0d expected 10000 0 0 0",
                  {in_ready, busy, shift_en, out_valid, chk_err}, out_quotient, out_reminder, dp_divident);
      end
      repeat (2) @(posedge sys_clock);
      #1 reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge sys_clock); #1;
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL mid_run_no_output: got %0d out_valid cycles expected 0", pulses);
      end
      run_txn(SIZE'(1000), lat, se, q, r, e);
      checks++;
      if (q !== SIZE'(333) || r !== 2'd1 || e !== 1'b0 || lat !== 7) begin
         errors++;
         $display("FAIL after_reset_1000: got %0d r%0d err%0d lat%0d expected 333 r1 err0 lat7",
                  q, r, e, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_error_inject();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
